// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] op;
  logic [XLEN-1:0] mcand, mplier, result;
  logic [2*XLEN-1:0] acc, acc_fix;
  logic [CW-1:0] cnt;
  logic neg, accept, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0] sum;
  // operand conditioning, one shift-add step and final sign fix-up
  always_comb begin
    accept = (state == IDLE || state == DONE) && start_i;
    neg_a = (op_i == OP_MULH || op_i == OP_MULHSU) && a_i[XLEN-1];
    neg_b = (op_i == OP_MULH) && b_i[XLEN-1];
    mag_a = neg_a ? -a_i : a_i;
    mag_b = neg_b ? -b_i : b_i;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mplier[0] ? mcand : {XLEN{1'b0}}};
    acc_fix = neg ? -acc : acc;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state logic; flush only matters while an operation is in flight
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = start_i ? CALC : IDLE;
      CALC: state_nxt = flush_i ? IDLE : (cnt == CW'(1) ? FIX : CALC);
      FIX:  state_nxt = flush_i ? IDLE : DONE;
      DONE: state_nxt = start_i ? CALC : IDLE;
    endcase
  end
  // outputs decoded from registered state only
  always_comb begin
    busy_o = state == CALC || state == FIX;
    done_o = state == DONE;
    result_o = result;
  end
  // datapath: latch magnitudes on accept, shift-add in CALC, negate and publish in FIX
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op <= OP_MUL;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      neg <= 1'b0;
      cnt <= '0;
      result <= '0;
    end else if (accept) begin
      op <= op_i;
      mcand <= mag_a;
      mplier <= mag_b;
      neg <= neg_a ^ neg_b;
      acc <= '0;
      cnt <= CW'(XLEN);
    end else if (state == CALC) begin
      acc <= {sum, acc[XLEN-1:1]};
      mplier <= mplier >> 1;
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      acc <= acc_fix;
      if (!flush_i) result <= op == OP_MUL ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for the iterative multiplier
module tb_seq_multiplier;
  logic clk, rst_n, start, flush, busy, done;
  logic [1:0] op;
  logic [31:0] a, b, result, last_exp, exp;
  logic [31:0] exp_q[$];
  int errors, checks;

  seq_multiplier #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint ex, ey, p;
    ex = (o == 2'd1 || o == 2'd2) ? longint'($signed(x)) : longint'({32'b0, x});
    ey = (o == 2'd1) ? longint'($signed(y)) : longint'({32'b0, y});
    p = ex * ey;
    return o == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_operand();
    int s;
    s = $urandom_range(0, 7);
    return s == 0 ? 32'h8000_0000 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h0 : s == 3 ? 32'h1 : $urandom;
  endfunction

  // drives one start cycle, pushes the model result, scrambles inputs afterwards
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; flush = fl;
    exp_q.push_back(ref_mul(o, x, y));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // counts negedges from the first CALC cycle until done_o, bounded
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    rst_n = 1'b1;
    last_exp = '0;
  endtask

  task automatic test_mul_timing();
    int n, nb;
    issue(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    n = 1; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front(); last_exp = exp;
    checks++; if (n !== 34) begin errors++; $display("FAIL mul_latency got %0d want 34", n); end
    checks++; if (nb !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d want 33", nb); end
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_neg3 got %h want ffffffeb", result); end
    checks++; if (result !== exp) begin errors++; $display("FAIL mul_scoreboard got %h want %h", result, exp); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_directed();
    logic [1:0] vo[6] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] va[6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] vb[6] = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vr[6] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h0};
    int n;
    for (int i = 0; i < 6; i++) begin
      issue(vo[i], va[i], vb[i], 1'b0);
      wait_done(1, n);
      exp = exp_q.pop_front(); last_exp = exp;
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL directed_%0d got %h want %h", i, result, vr[i]); end
      checks++; if (result !== exp || n !== 34) begin errors++; $display("FAIL directed_sb_%0d got %h/%0d want %h/34", i, result, n, exp); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 250; i++) begin
      issue(2'($urandom), rnd_operand(), rnd_operand(), 1'b0);
      wait_done(1, n);
      exp = exp_q.pop_front(); last_exp = exp;
      checks++; if (result !== exp || n !== 34) begin errors++; $display("FAIL random_%0d got %h/%0d want %h/34", i, result, n, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int ndone, nissued, last;
    ndone = 0; nissued = 0; last = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 200 && ndone < 4; n++) begin
      if (done) begin
        exp = exp_q.pop_front(); last_exp = exp;
        checks++; if (result !== exp) begin errors++; $display("FAIL b2b_result_%0d got %h want %h", ndone, result, exp); end
        if (ndone > 0) begin
          checks++; if (n - last !== 34) begin errors++; $display("FAIL b2b_interval_%0d got %0d want 34", ndone, n - last); end
        end
        last = n;
        ndone++;
      end
      if (!busy && start) begin
        if (nissued == 4) start = 1'b0;
        else begin
          op = 2'($urandom); a = rnd_operand(); b = rnd_operand();
          exp_q.push_back(ref_mul(op, a, b));
          nissued++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (ndone !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", ndone); end
  endtask

  task automatic test_ignore_start();
    int n;
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (5) @(negedge clk);
    op = 2'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, n);
    exp = exp_q.pop_front(); last_exp = exp;
    checks++; if (result !== exp || n !== 34) begin errors++; $display("FAIL ignore_start got %h/%0d want %h/34", result, n, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_second got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_flush();
    int n, nd;
    issue(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_idle_blocks got busy=%b want 1", busy); end
    wait_done(1, n);
    exp = exp_q.pop_front(); last_exp = exp;
    checks++; if (result !== exp) begin errors++; $display("FAIL flush_idle_result got %h want %h", result, exp); end
    issue(2'd2, 32'hCAFE_0001, 32'h7777_7777, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_abort got busy=%b done=%b want 0 0", busy, done); end
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", nd); end
    checks++; if (result !== last_exp) begin errors++; $display("FAIL flush_hold got %h want %h", result, last_exp); end
    void'(exp_q.pop_back());
  endtask

  task automatic test_reset_mid();
    int n;
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL reset_mid got busy=%b done=%b result=%h want 0 0 0", busy, done, result); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(1, n);
    exp = exp_q.pop_front(); last_exp = exp;
    checks++; if (result !== exp || n !== 34) begin errors++; $display("FAIL reset_fresh got %h/%0d want %h/34", result, n, exp); end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_mul_timing();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
